// File: rtl/spram_burst_reader_pkg.sv
// Shared types for the single-port RAM burst reader.
package spram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } burst_state_t;

endpackage

// File: rtl/spram_burst_reader_if.sv
// RAM bus and output stream signals of the burst reader.
interface spram_burst_reader_if #(
    parameter int addr_width = 8,
    parameter int data_width = 8
);
    logic                  mem_cs;
    logic                  mem_wren;
    logic [addr_width-1:0] mem_address;
    logic [data_width-1:0] mem_q;
    logic                  out_valid;
    logic [data_width-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output mem_cs, mem_wren, mem_address,
        input  mem_q,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_cs, mem_wren, mem_address,
        output mem_q,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/spram_burst_reader_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int width = 9,
    parameter int depth = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [width-1:0]       wdata,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);
    localparam int ptr_w = $clog2(depth);

    logic [width-1:0] storage_q [depth];
    logic [ptr_w-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ptr_w:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ptr_w+1)'(depth));
    assign count   = count_q;
    assign rdata   = storage_q[rd_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + ptr_w'(1);
            if (pop_ok)  rd_d = rd_q + ptr_w'(1);
            if (push_ok && !pop_ok)      count_d = count_q + (ptr_w+1)'(1);
            else if (pop_ok && !push_ok) count_d = count_q - (ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) storage_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/spram_burst_reader.sv
// Read engine: walks an address range on the single-port RAM and streams the words out.
module spram_burst_reader
    import spram_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 8,
    parameter int fifo_depth = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    input  logic [addr_width:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    spram_burst_reader_if.master  bus
);
    localparam int cnt_w = $clog2(fifo_depth) + 1;

    burst_state_t          state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [addr_width:0]   remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cs, last_tag;
    logic                  fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [cnt_w-1:0]      fifo_count;
    logic [data_width:0]   fifo_rdata;
    logic                  head_last;
    logic [data_width-1:0] head_data;

    assign head_last = fifo_rdata[data_width];
    assign head_data = fifo_rdata[data_width-1:0];
    assign fifo_pop  = !fifo_empty && bus.out_ready;
    assign last_tag  = (remaining_q == (addr_width+1)'(1));

    // A read may issue into a full FIFO when the head leaves in the same cycle.
    assign cs = (state_q == FETCH) && (remaining_q != '0) && (!fifo_full || fifo_pop);
    assign fifo_flush = abort && ((state_q == FETCH) || (state_q == DRAIN));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = length;
                    state_d     = (length != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (cs) begin
                    addr_d      = addr_q + addr_width'(1);
                    remaining_d = remaining_q - (addr_width+1)'(1);
                end
                if (abort)                  state_d = IDLE;
                else if (remaining_d == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                       state_d = IDLE;
                else if (fifo_pop && head_last)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    sync_fifo #(
        .width (data_width + 1),
        .depth (fifo_depth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cs),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata ({last_tag, bus.mem_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.mem_cs      = cs;
    assign bus.mem_wren    = 1'b0;
    assign bus.mem_address = addr_q;
    assign bus.out_valid   = (fifo_count != '0);
    assign bus.out_data    = fifo_empty ? '0 : head_data;
    assign bus.out_last    = !fifo_empty && head_last;
endmodule

// File: tb/tb_spram_burst_reader.sv
// Randomized bench for spram_burst_reader against a word-stream reference model.
module tb_spram_burst_reader;
    logic       clock = 1'b0;
    logic       reset, start, abort;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic       busy, done;
    logic [7:0] ram [256];
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    spram_burst_reader_if #(.addr_width(8), .data_width(8)) bus ();

    // RAM model: combinational read, all-ones while deselected.
    assign bus.mem_q = bus.mem_cs ? ram[bus.mem_address] : 8'hFF;

    spram_burst_reader #(.addr_width(8), .data_width(8), .fifo_depth(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    task automatic fill_ram(input bit rnd);
        for (int i = 0; i < 256; i++) ram[i] = rnd ? 8'($urandom) : (8'(i) ^ 8'hA5);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({busy, done, bus.mem_cs, bus.mem_address, bus.out_valid, bus.out_data, bus.out_last} !== 21'h0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b cs=%b addr=%h valid=%b data=%h last=%b required all zero",
                     tag, busy, done, bus.mem_cs, bus.mem_address, bus.out_valid, bus.out_data, bus.out_last);
        end
    endtask

    // One burst; mode 0: ready high, 1: ready low for cycles 1..10, 2: random ready.
    task automatic run_burst(input logic [7:0] sa, input int len, input int mode,
                             input bit do_abort, input bit probe);
        int issued = 0, accepted = 0, last_pop = -1, abort_cyc = -1, occ;
        bit ready, exp_cs, exp_valid, exp_busy, exp_done, after_abort, finished = 0;
        logic [7:0] exp_addr, exp_word;
        @(posedge clock); #1;
        start = 1'b1; start_addr = sa; length = 9'(len); abort = 1'b0; bus.out_ready = 1'b1;
        if (len == 0) last_pop = 0;
        for (int c = 1; c <= 700 && !finished; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (probe && c == 2) begin
                start = 1'b1; start_addr = sa + 8'h40; length = 9'd3;
            end
            abort = 1'b0;
            if (do_abort && abort_cyc < 0 && accepted >= 2) begin
                abort = 1'b1; abort_cyc = c;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (c > 10);
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            bus.out_ready = ready;
            @(negedge clock);
            after_abort = (abort_cyc >= 0) && (c > abort_cyc);
            occ       = issued - accepted;
            exp_cs    = !after_abort && (issued < len) && (ready || occ < 4);
            exp_valid = !after_abort && (occ > 0);
            exp_busy  = !after_abort && !(last_pop >= 0 && c >= last_pop + 2);
            exp_done  = !after_abort && (last_pop >= 0) && (c == last_pop + 2);
            checks++;
            if (bus.mem_cs !== exp_cs) begin
                failures++;
                $display("FAIL mem_cs c=%0d: got %b required %b", c, bus.mem_cs, exp_cs);
            end
            if (exp_cs) begin
                exp_addr = sa + 8'(issued);
                checks++;
                if (bus.mem_address !== exp_addr) begin
                    failures++;
                    $display("FAIL mem_address c=%0d: got %h required %h", c, bus.mem_address, exp_addr);
                end
            end
            checks++;
            if (bus.mem_wren !== 1'b0) begin
                failures++;
                $display("FAIL mem_wren c=%0d: got %b required 0", c, bus.mem_wren);
            end
            checks++;
            if (bus.out_valid !== exp_valid) begin
                failures++;
                $display("FAIL out_valid c=%0d: got %b required %b", c, bus.out_valid, exp_valid);
            end
            if (exp_valid) begin
                exp_word = ram[sa + 8'(accepted)];
                checks++;
                if (bus.out_data !== exp_word || bus.out_last !== (accepted == len - 1)) begin
                    failures++;
                    $display("FAIL out_word c=%0d: got data=%h last=%b required data=%h last=%b",
                             c, bus.out_data, bus.out_last, exp_word, (accepted == len - 1));
                end
            end
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("FAIL busy_done c=%0d: got busy=%b done=%b required busy=%b done=%b",
                         c, busy, done, exp_busy, exp_done);
            end
            if (exp_valid && ready) begin
                if (accepted == len - 1) last_pop = c;
                accepted++;
            end
            if (exp_cs) issued++;
            if ((last_pop >= 0 && c == last_pop + 3) || (after_abort && c == abort_cyc + 4)) finished = 1;
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL timeout: burst sa=%h len=%0d not complete, got %0d words required %0d", sa, len, accepted, len);
        end
        if (!do_abort) begin
            exp_addr = sa + 8'(len);
            checks++;
            if (bus.mem_address !== exp_addr) begin
                failures++;
                $display("FAIL final_address: got %h required %h", bus.mem_address, exp_addr);
            end
        end
        start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; length = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset_values");
    endtask

    task automatic test_basic();
        fill_ram(1'b0);
        run_burst(8'h10, 4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_burst(8'h10, 4, 1, 1'b0, 1'b0);
        run_burst(8'h30, 9, 1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_burst(8'hFE, 4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_length();
        run_burst(8'h55, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_burst(8'h80, 8, 0, 1'b1, 1'b0);
        run_burst(8'h90, 5, 0, 1'b0, 1'b0);
        run_burst(8'hA0, 12, 2, 1'b1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_burst(8'h20, 6, 2, 1'b0, 1'b1);
    endtask

    task automatic test_full_range();
        fill_ram(1'b1);
        run_burst(8'($urandom), 256, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            fill_ram(1'b1);
            run_burst(8'($urandom), int'($urandom_range(1, 40)), 2, 1'b0, ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid();
        fill_ram(1'b0);
        @(posedge clock); #1;
        start = 1'b1; start_addr = 8'h20; length = 9'd8; bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("reset_mid_burst");
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check_idle_outputs("reset_mid_after");
        run_burst(8'h40, 3, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_length();
        test_abort();
        test_start_while_busy();
        test_full_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
